lpc_excitation_gen: RTL
=======================

Name: lpc_excitation_gen

Overview:
- Excitation source for the LPC synthesis path. It sits directly upstream of the decoder's all-pole synthesis filter.
- Consumes per-frame parameters from the LPC encoder (valid strobe, voiced flag, pitch period in samples, gain).
- Emits one signed excitation sample per sample strobe:
  - voiced frames: a periodic impulse train;
  - unvoiced frames: LFSR noise.
- Parameters arriving mid-frame are double-buffered and applied only at frame boundaries.

Parameters:
DATA_W, 16, width of excitation sample, pitch and gain fields
FRAME_LEN, 240, samples per LPC frame (matches lpcrate)
LFSR_SEED, 16'hACE1, noise LFSR reset/seed value (must be nonzero)
MIN_PITCH, 2, smallest legal pitch period; smaller pulserate values are clamped up to it

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
d_clk  in  1  sample strobe, single-cycle pulse synchronous to clk, one per audio sample
v  in  1  frame-parameter valid, single-cycle pulse
voiced  in  1  1 = voiced frame, 0 = unvoiced
pulserate  in  DATA_W  pitch period in samples (unsigned)
gain  in  DATA_W  excitation amplitude (unsigned; bit 15 ignored, treated as 0..32767)
exc  out  DATA_W  signed excitation sample
exc_vout  out  1  1-cycle pulse, exc valid
frame_done  out  1  1-cycle pulse on the last sample of each frame
overrun  out  1  sticky: v arrived while a pending set was not yet consumed
running  out  1  high in RUN state

Behaviour:
Reset (async, rst_n=0):
- exc=0, exc_vout=0, frame_done=0, overrun=0, running=0.
- State = IDLE. Sample and pitch counters = 0. LFSR = LFSR_SEED. Active and shadow parameter sets cleared; pending=0.
- Reset asserted mid-frame aborts immediately. After release, the block waits for a fresh v.

Parameter capture:
- On v, {voiced, max(pulserate, MIN_PITCH), gain & 16'h7FFF} is written into the shadow set and pending is set to 1.
- If pending was already 1, the shadow set is overwritten and overrun is set (sticky until reset).

States:
- IDLE: no output activity. d_clk is ignored.
  - On v: load the inputs directly into the active set (bypassing shadow; pending stays 0), clear the sample and pitch counters, go to RUN.
- RUN: each d_clk produces one sample.
  - Sample counter runs 0..FRAME_LEN-1.
  - At count FRAME_LEN-1: frame_done pulses with that sample and the counter wraps to 0.
  - If pending is set at the wrap, shadow is copied to active and pending clears.
  - With nothing pending, the active set is reused (hold last frame). The block never returns to IDLE except via reset.

Simultaneous events:
- v in the same cycle as the wrapping d_clk: the new inputs are applied at this boundary, bypassing shadow; pending stays 0.
- v in the same cycle as a non-wrap d_clk: captured to shadow; the current sample uses the old active set.

Sample generation (registered; exc and exc_vout are valid 1 cycle after d_clk):
- Voiced:
  - exc = +gain when the pitch counter == 0, else 0.
  - Pitch counter increments each d_clk and wraps to 0 at pitch-1.
  - The pitch counter is not reset at a voiced->voiced boundary (phase continuity).
  - It is reset to 0 on an unvoiced->voiced boundary or the IDLE->RUN entry, so the first voiced sample is a pulse.
- Unvoiced:
  - LFSR is Galois, 16-bit, polynomial x^16+x^14+x^13+x^11+1 (shift right, XOR mask 16'hB400 when the LSB is 1).
  - It advances once per d_clk in RUN, in both voiced and unvoiced frames.
  - exc = LSB (pre-advance) ? +(gain>>1) : -(gain>>1), two's complement.
  - Pitch counter held at 0.
- exc holds its value between strobes. exc_vout is high only in the cycle after an accepted d_clk.
- No arithmetic overflow is possible: gain ≤ 32767 and the negation of gain>>1 fits in 16 bits.

Test Plan:
- Reset release then 5 d_clk with no v -> exc=0, exc_vout never asserts, running=0.
- v{voiced=1, pulserate=80, gain=1000}, then 240 d_clk -> exc=1000 at samples 0, 80 and 160 (3 pulses), 0 elsewhere; exc_vout 240 pulses, each 1 cycle after d_clk; frame_done on sample 239 only.
- Frame 1 as above; at sample 100 inject v{voiced=1, pulserate=50, gain=2000} -> frame 1 unchanged. Frame 2 starts with the pitch counter continuing from 240 mod 80 = 0, so pulses of 2000 occur at frame-2 samples 0, 50, 100.
- v{voiced=0, gain=4000}, first 4 d_clk -> LFSR states ACE1, E270, 7138, 389C → exc LSBs 1, 0, 0, 0 → exc = +2000, -2000, -2000, -2000.
- Two v pulses inside one frame, the second {pulserate=1} -> overrun=1 and stays high. The next frame uses the second set with the pitch clamped to 2 (pulse every other sample).
- v coincident with the wrapping d_clk (sample 239) -> new parameters take effect at the next frame's sample 0, pending stays 0, no overrun. Then assert rst_n=0 mid-frame -> all outputs 0 immediately and LFSR back to ACE1.

Source files
------------

// File: rtl/lpc_excitation_gen_if.sv
`default_nettype none
// ---- lpc_excitation_gen_if | frame-parameter input / excitation-sample output bundle ----
// ---- rev 1.0 ----
interface lpc_excitation_gen_if #(
  parameter int DATA_W = 16
);
  logic              d_clk;
  logic              v;
  logic              voiced;
  logic [DATA_W-1:0] pulserate;
  logic [DATA_W-1:0] gain;
  logic [DATA_W-1:0] exc;
  logic              exc_vout;
  logic              frame_done;
  logic              overrun;
  logic              running;

  modport master (
    output d_clk, v, voiced, pulserate, gain,
    input  exc, exc_vout, frame_done, overrun, running
  );

  modport slave (
    input  d_clk, v, voiced, pulserate, gain,
    output exc, exc_vout, frame_done, overrun, running
  );
endinterface
`default_nettype wire

// File: rtl/lpc_excitation_gen.sv
`default_nettype none
// ---- lpc_excitation_gen | voiced impulse-train / LFSR-noise excitation for LPC synthesis ----
// ---- rev 1.0 ----
module lpc_excitation_gen #(
  parameter int          DATA_W    = 16,
  parameter int          FRAME_LEN = 240,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          MIN_PITCH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  lpc_excitation_gen_if.slave bus
);
  localparam int                CNT_W     = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [DATA_W-1:0] ONE       = DATA_W'(1);
  localparam logic [DATA_W-1:0] MIN_P     = DATA_W'(MIN_PITCH);
  localparam logic [DATA_W-1:0] GAIN_MASK = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [15:0]       LFSR_MASK = 16'hB400;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic              voiced;
    logic [DATA_W-1:0] pitch;
    logic [DATA_W-1:0] gain;
  } pset_t;

  state_t            state_q, state_d;
  pset_t             act_q, shd_q, in_set, act_next;
  logic              pending_q, overrun_q;
  logic [CNT_W-1:0]  smp_q;
  logic [DATA_W-1:0] pc_q, pc_inc, pc_next;
  logic [15:0]       lfsr_q, lfsr_nxt;
  logic [DATA_W-1:0] exc_q, sample, half;
  logic              vout_q, fd_q;
  logic              start, accept, wrap, shadow_wr;
  logic [DATA_W-1:0] in_pitch;

  // Incoming parameter set, already clamped and masked so every path loads the same form.
  assign in_pitch = (bus.pulserate < MIN_P) ? MIN_P : bus.pulserate;
  assign in_set   = {bus.voiced, in_pitch, bus.gain & GAIN_MASK};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    accept    = 1'b0;
    wrap      = 1'b0;
    shadow_wr = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.v) begin
          start   = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        accept    = bus.d_clk;
        wrap      = bus.d_clk && (smp_q == CNT_LAST);
        shadow_wr = bus.v && !wrap;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lfsr_nxt = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
    half     = act_q.gain >> 1;
    if (act_q.voiced) sample = (pc_q == '0) ? act_q.gain : '0;
    else              sample = lfsr_q[0] ? half : -half;
    pc_inc   = (!act_q.voiced || (pc_q >= (act_q.pitch - ONE))) ? '0 : (pc_q + ONE);
    act_next = act_q;
    if (bus.v)          act_next = in_set;
    else if (pending_q) act_next = shd_q;
    // Phase carries across a boundary only when both frames are voiced.
    pc_next  = (act_next.voiced && act_q.voiced) ? pc_inc : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q     <= '0;
      shd_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      smp_q     <= '0;
      pc_q      <= '0;
      lfsr_q    <= LFSR_SEED;
      exc_q     <= '0;
      vout_q    <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      vout_q <= accept;
      fd_q   <= wrap;
      if (start) begin
        act_q <= in_set;
        smp_q <= '0;
        pc_q  <= '0;
      end
      if (accept) begin
        exc_q  <= sample;
        lfsr_q <= lfsr_nxt;
        smp_q  <= wrap ? '0 : (smp_q + CNT_ONE);
        pc_q   <= wrap ? pc_next : pc_inc;
      end
      if (wrap) begin
        act_q     <= act_next;
        pending_q <= 1'b0;
      end
      if (shadow_wr) begin
        shd_q     <= in_set;
        pending_q <= 1'b1;
      end
      if (bus.v && pending_q) overrun_q <= 1'b1;
    end
  end

  assign bus.exc        = exc_q;
  assign bus.exc_vout   = vout_q;
  assign bus.frame_done = fd_q;
  assign bus.overrun    = overrun_q;
  assign bus.running    = (state_q == RUN);
endmodule
`default_nettype wire
